// File: rtl/stack_seq_if.sv
// Bus bundle for stack_seq: command inputs, stack-pointer and RAM handshakes, result strobes.
//   master : command/environment side (drives commands, sp_value, ram_rdata)
//   slave  : the sequencer itself
interface stack_seq_if;
  // Commands and their operands
  logic        cmd_call;
  logic        cmd_ret;
  logic        cmd_push;
  logic        cmd_pop;
  logic [15:0] pc_in;
  logic [7:0]  push_data;
  // Stack pointer handshake
  logic [7:0]  sp_value;
  logic        sp_inc;
  logic        sp_dec;
  // RAM port
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [7:0]  ram_rdata;
  // Results and status
  logic [15:0] pc_out;
  logic        pc_load;
  logic [7:0]  pop_data;
  logic        pop_valid;
  logic        busy;
  logic        err;

  modport master (
    output cmd_call, cmd_ret, cmd_push, cmd_pop, pc_in, push_data, sp_value, ram_rdata,
    input  sp_inc, sp_dec, ram_addr, ram_wdata, ram_we, ram_re,
    input  pc_out, pc_load, pop_data, pop_valid, busy, err
  );

  modport slave (
    input  cmd_call, cmd_ret, cmd_push, cmd_pop, pc_in, push_data, sp_value, ram_rdata,
    output sp_inc, sp_dec, ram_addr, ram_wdata, ram_we, ram_re,
    output pc_out, pc_load, pop_data, pop_valid, busy, err
  );
endinterface

// File: rtl/stack_seq.sv
// stack_seq: call/return and byte push/pop sequencer for an 8-bit RAM stack.
// The stack grows upward; sp_value points at the top occupied byte. CALL pushes the low
// byte then the high byte of the return address; RET pops them in reverse order.
//
// Ports:
//   clock   : system clock, all state changes on the rising edge
//   reset   : asynchronous, active-high
//   bus_io  : stack_seq_if.slave
//     cmd_call/cmd_ret/cmd_push/cmd_pop, pc_in, push_data  - commands, sampled in idle
//     sp_value / sp_inc / sp_dec                            - external stack pointer
//     ram_addr/ram_wdata/ram_we/ram_re/ram_rdata            - RAM, one-cycle read latency
//     pc_out/pc_load, pop_data/pop_valid                    - results with one-cycle strobes
//     busy, err                                             - status, err = underflow strobe
module stack_seq #(
  parameter logic [7:0] SP_FLOOR = 8'h07  // sp_value meaning "stack empty"
) (
  input  logic        clock,
  input  logic        reset,
  stack_seq_if.slave  bus_io
);

  localparam logic [3:0] StIdle = 4'd0;
  localparam logic [3:0] StWLo  = 4'd1;
  localparam logic [3:0] StWHi  = 4'd2;
  localparam logic [3:0] StWOne = 4'd3;
  localparam logic [3:0] StRHi  = 4'd4;
  localparam logic [3:0] StRLo  = 4'd5;
  localparam logic [3:0] StRFin = 4'd6;
  localparam logic [3:0] StROne = 4'd7;
  localparam logic [3:0] StRCap = 4'd8;

  logic [3:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;          // return address captured at accept
  logic [7:0]  byte_q, byte_d;      // push byte captured at accept
  logic [7:0]  hi_q, hi_d;          // high byte of a RET in flight
  logic [15:0] pc_out_q, pc_out_d;
  logic [7:0]  pop_data_q, pop_data_d;
  logic        pc_load_q, pc_load_d;
  logic        pop_valid_q, pop_valid_d;
  logic        err_q, err_d;

  logic        ret_uflow;
  logic        pop_uflow;
  logic [7:0]  sp_plus1;

  // RET needs two bytes above the floor, POP needs one; widen so a floor near 8'hFF
  // does not wrap the comparison.
  assign ret_uflow = ({1'b0, bus_io.sp_value} < ({1'b0, SP_FLOOR} + 9'd2));
  assign pop_uflow = (bus_io.sp_value <= SP_FLOOR);
  assign sp_plus1  = bus_io.sp_value + 8'd1;  // wraps modulo 256, no overflow flag

  // Next-state and result capture
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    byte_d      = byte_q;
    hi_d        = hi_q;
    pc_out_d    = pc_out_q;
    pop_data_d  = pop_data_q;
    pc_load_d   = 1'b0;
    pop_valid_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      StIdle: begin
        // Priority call > ret > push > pop; lower-priority requests are dropped.
        if (bus_io.cmd_call) begin
          pc_d    = bus_io.pc_in;
          byte_d  = bus_io.push_data;
          state_d = StWLo;
        end else if (bus_io.cmd_ret) begin
          if (ret_uflow) begin
            err_d = 1'b1;
          end else begin
            pc_d    = bus_io.pc_in;
            byte_d  = bus_io.push_data;
            state_d = StRHi;
          end
        end else if (bus_io.cmd_push) begin
          pc_d    = bus_io.pc_in;
          byte_d  = bus_io.push_data;
          state_d = StWOne;
        end else if (bus_io.cmd_pop) begin
          if (pop_uflow) begin
            err_d = 1'b1;
          end else begin
            pc_d    = bus_io.pc_in;
            byte_d  = bus_io.push_data;
            state_d = StROne;
          end
        end
      end
      StWLo:  state_d = StWHi;
      StWHi:  state_d = StIdle;
      StWOne: state_d = StIdle;
      StRHi:  state_d = StRLo;
      StRLo: begin
        // Read data from the StRHi access (high byte) arrives now.
        hi_d    = bus_io.ram_rdata;
        state_d = StRFin;
      end
      StRFin: begin
        // Publish the whole address at once so pc_out never shows a half-updated value.
        pc_out_d  = {hi_q, bus_io.ram_rdata};
        pc_load_d = 1'b1;
        state_d   = StIdle;
      end
      StROne: state_d = StRCap;
      StRCap: begin
        pop_data_d  = bus_io.ram_rdata;
        pop_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // RAM and stack-pointer strobes, decoded from the current state only
  always_comb begin
    bus_io.sp_inc    = 1'b0;
    bus_io.sp_dec    = 1'b0;
    bus_io.ram_we    = 1'b0;
    bus_io.ram_re    = 1'b0;
    bus_io.ram_addr  = 8'h00;
    bus_io.ram_wdata = 8'h00;

    case (state_q)
      StWLo: begin
        bus_io.sp_inc    = 1'b1;
        bus_io.ram_we    = 1'b1;
        bus_io.ram_addr  = sp_plus1;
        bus_io.ram_wdata = pc_q[7:0];
      end
      StWHi: begin
        bus_io.sp_inc    = 1'b1;
        bus_io.ram_we    = 1'b1;
        bus_io.ram_addr  = sp_plus1;
        bus_io.ram_wdata = pc_q[15:8];
      end
      StWOne: begin
        bus_io.sp_inc    = 1'b1;
        bus_io.ram_we    = 1'b1;
        bus_io.ram_addr  = sp_plus1;
        bus_io.ram_wdata = byte_q;
      end
      StRHi, StRLo, StROne: begin
        bus_io.sp_dec   = 1'b1;
        bus_io.ram_re   = 1'b1;
        bus_io.ram_addr = bus_io.sp_value;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= 16'h0000;
      byte_q      <= 8'h00;
      hi_q        <= 8'h00;
      pc_out_q    <= 16'h0000;
      pop_data_q  <= 8'h00;
      pc_load_q   <= 1'b0;
      pop_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      byte_q      <= byte_d;
      hi_q        <= hi_d;
      pc_out_q    <= pc_out_d;
      pop_data_q  <= pop_data_d;
      pc_load_q   <= pc_load_d;
      pop_valid_q <= pop_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus_io.pc_out    = pc_out_q;
  assign bus_io.pc_load   = pc_load_q;
  assign bus_io.pop_data  = pop_data_q;
  assign bus_io.pop_valid = pop_valid_q;
  assign bus_io.err       = err_q;
  assign bus_io.busy      = (state_q != StIdle);

endmodule
